// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant sequencer: sizes, FSM
// encoding and the rotating priority search.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Search starts just after the last winner. The request vector is rotated
  // so that position becomes bit 0, the lowest set bit is found, and the
  // offset is added back to the start index (wraps mod NUM_REQ).
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [IDX_W-1:0]   last
  );
    logic [IDX_W-1:0]     start;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;
    start = last + IDX_W'(1);
    dbl   = {req, req};
    rot   = dbl[start +: NUM_REQ];
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    return start + off;
  endfunction

endpackage

// File: rtl/rr_grant_sequencer_if.sv
// Requester-side bus of the grant sequencer: request/release inputs and
// the registered grant outputs.
interface rr_grant_sequencer_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;
  logic               busy;

  // Requesting blocks drive req/done and observe the grant.
  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout, busy
  );

  // The arbiter consumes req/done and drives the grant.
  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout, busy
  );

endinterface

// File: rtl/grant_decoder.sv
// 2-to-4 enable decoder turning the winner index into a one-hot grant.
module grant_decoder import arb_pkg::*; (
  input  logic [IDX_W-1:0]   gnt_idx_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  // One-hot select when enabled, all zero otherwise.
  always_comb begin
    gnt_o = '0;
    if (en_i) gnt_o[gnt_idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Four-requester round-robin grant sequencer. A winner holds the shared
// resource until it strobes done, drops its request or the hold timer
// expires; a fixed RELEASE+IDLE gap separates consecutive owners so the
// decoder enable always drops between them.
module rr_grant_sequencer #(
  parameter  int MAX_HOLD = 16,
  localparam int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_grant_sequencer_if.slave bus
);
  import arb_pkg::*;

  localparam bit               TMO_EN    = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmo_d;
  logic [NUM_REQ-1:0] gnt_d, gnt_q;
  logic               vld_q, tmo_q, busy_q;

  // Next-state, winner selection, hold timer and release cause.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req != '0) begin
          idx_d   = rr_pick(bus.req, last_q);
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (cnt_q != HOLD_SAT) cnt_d = cnt_q + CNT_W'(1);
        // Owner release and request drop win over the timer.
        if (bus.done || !bus.req[idx_q]) begin
          state_d = RELEASE;
          last_d  = idx_q;
        end else if (TMO_EN && cnt_q == HOLD_LAST) begin
          state_d = RELEASE;
          last_d  = idx_q;
          tmo_d   = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode from next-state values so the grant lands in the output register.
  grant_decoder u_dec (
    .gnt_idx_i (idx_d),
    .en_i      (state_d == GRANT),
    .gnt_o     (gnt_d)
  );

  // FSM state and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      vld_q   <= (state_d == GRANT);
      tmo_q   <= tmo_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = vld_q;
  assign bus.timeout   = tmo_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Bench for rr_grant_sequencer: directed scenarios plus random traffic,
// checked against an owner/hold-count reference model via a scoreboard.
module tb_rr_grant_sequencer;

  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n;

  rr_grant_sequencer_if bus();

  rr_grant_sequencer #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       tmo;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: who owns the resource, how long it has held it,
  // whether we are in the post-release gap, and the last winner.
  int m_owner, m_held, m_last, m_idx;
  bit m_rel, m_tmo;

  function automatic void model_reset();
    m_owner = -1; m_held = 0; m_last = 3; m_idx = 0; m_rel = 0; m_tmo = 0;
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic d);
    m_tmo = 0;
    if (m_owner >= 0) begin
      m_held++;
      if (d || !r[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_rel = 1;
      end else if (MH != 0 && m_held == MH) begin
        m_last = m_owner; m_owner = -1; m_rel = 1; m_tmo = 1;
      end
    end else if (m_rel) begin
      m_rel = 0;
    end else if (r != 4'b0) begin
      for (int k = 1; k <= 4; k++) begin
        if (r[(m_last + k) % 4]) begin
          m_owner = (m_last + k) % 4;
          break;
        end
      end
      m_idx  = m_owner;
      m_held = 0;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.gnt  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    e.idx  = 2'(m_idx);
    e.vld  = (m_owner >= 0);
    e.tmo  = m_tmo;
    e.busy = (m_owner >= 0) || m_rel;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  task automatic drive_push(input logic [3:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    model_step(r, d);
    exp_q.push_back(model_out());
  endtask

  // Drive one cycle of inputs, return after that edge's outputs are stable.
  task automatic tick(input logic [3:0] r, input logic d);
    @(negedge clk);
    drive_push(r, d);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: one expected entry per checked edge.
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout, bus.busy};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t: gnt=%b idx=%0d v=%b to=%b busy=%b want gnt=%b idx=%0d v=%b to=%b busy=%b",
                 $time, a.gnt, a.idx, a.vld, a.tmo, a.busy, e.gnt, e.idx, e.vld, e.tmo, e.busy);
      end
      total++;
      if (!$onehot0(bus.gnt) || (bus.gnt_valid !== (|bus.gnt))) begin
        bad++;
        $display("FAIL invariant: gnt=%b gnt_valid=%b", bus.gnt, bus.gnt_valid);
      end
    end
  end

  initial begin
    logic [3:0] seq[$];
    int         gaps[$];
    logic [3:0] want_seq [5];
    logic [3:0] prev, g;
    int         zr, run;

    // Reset with all requesting.
    rst_n = 1'b0; bus.req = 4'b1111; bus.done = 1'b0;
    model_reset();
    #12;
    chk("rst_gnt",  bus.gnt, 4'b0);
    chk("rst_idx",  bus.gnt_idx, 2'd0);
    chk("rst_vld",  bus.gnt_valid, 1'b0);
    chk("rst_tmo",  bus.timeout, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_push(4'b1111, 1'b0);
    @(posedge clk); #2;
    chk("first_gnt", bus.gnt, 4'b0001);

    // Fairness: done in the 3rd cycle of every grant.
    seq.push_back(bus.gnt); prev = bus.gnt; zr = 0;
    for (int n = 0; n < 22; n++) begin
      tick(4'b1111, (m_owner >= 0 && m_held == 2));
      g = bus.gnt;
      if (g == 4'b0) zr++;
      else begin
        if (prev == 4'b0) begin seq.push_back(g); gaps.push_back(zr); end
        zr = 0;
      end
      prev = g;
    end
    want_seq[0] = 4'b0001; want_seq[1] = 4'b0010; want_seq[2] = 4'b0100;
    want_seq[3] = 4'b1000; want_seq[4] = 4'b0001;
    chk("fair_count", seq.size(), 5);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk("fair_seq", seq[i], want_seq[i]);
    for (int i = 0; i < gaps.size(); i++) chk("fair_gap", gaps[i], 2);

    // Timeout: requester 2 holds with no done.
    for (int n = 0; n < 8 && bus.gnt !== 4'b0100; n++) tick(4'b0100, 1'b0);
    chk("to_grant", bus.gnt, 4'b0100);
    run = 1;
    for (int n = 0; n < 8; n++) begin
      tick(4'b0100, 1'b0);
      if (bus.gnt == 4'b0100) run++;
      else break;
    end
    chk("to_len", run, MH);
    chk("to_pulse", bus.timeout, 1'b1);
    chk("to_rel_gnt", bus.gnt, 4'b0);
    tick(4'b0100, 1'b0);
    chk("to_idle_tmo", bus.timeout, 1'b0);
    chk("to_idle_busy", bus.busy, 1'b0);
    tick(4'b0100, 1'b0);
    chk("to_regrant", bus.gnt, 4'b0100);

    // done on the final hold cycle beats the timer.
    tick(4'b0100, 1'b0); tick(4'b0100, 1'b0); tick(4'b0100, 1'b0);
    tick(4'b0100, 1'b1);
    chk("done4_gnt", bus.gnt, 4'b0);
    chk("done4_tmo", bus.timeout, 1'b0);

    // Wrap: last=2, search 3,0,1 picks 0.
    tick(4'b0011, 1'b0);
    tick(4'b0011, 1'b0);
    chk("wrap_gnt", bus.gnt, 4'b0001);
    chk("wrap_idx", bus.gnt_idx, 2'd0);

    // Request drop by owner 1 in its 2nd grant cycle.
    tick(4'b0010, 1'b0); tick(4'b0010, 1'b0); tick(4'b0010, 1'b0);
    chk("drop_grant", bus.gnt, 4'b0010);
    tick(4'b0010, 1'b0);
    tick(4'b0000, 1'b0);
    chk("drop_gnt", bus.gnt, 4'b0);
    chk("drop_tmo", bus.timeout, 1'b0);
    tick(4'b1111, 1'b0);
    tick(4'b1111, 1'b0);
    chk("drop_next", bus.gnt, 4'b0100);

    // Async reset while requester 3 owns the grant.
    tick(4'b1000, 1'b0); tick(4'b1000, 1'b0); tick(4'b1000, 1'b0);
    chk("ar_grant", bus.gnt, 4'b1000);
    #1;
    rst_n = 1'b0;
    bus.req = 4'b1111;
    model_reset();
    #1;
    chk("ar_gnt",  bus.gnt, 4'b0);
    chk("ar_vld",  bus.gnt_valid, 1'b0);
    chk("ar_busy", bus.busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_push(4'b1111, 1'b0);
    @(posedge clk); #2;
    chk("ar_first", bus.gnt, 4'b0001);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] r;
      logic       d;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) r = bus.req;
      d = ($urandom_range(0, 5) == 0);
      tick(r, d);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
